// File: rtl/host_mem_wr_arb_pkg.sv
// Shared types and constants for the host-memory line-write arbiter.
package host_mem_wr_arb_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} t_state;

   localparam logic [2:0] LINE_AWSIZE = 3'b110;
   localparam int         LINE_BYTES  = 64;
   localparam int         N_REQ_DEF   = 4;

   typedef logic [$clog2(N_REQ_DEF)-1:0] t_req_idx;

   function automatic int next_rr(input int g, input int n);
      return (g + 1 == n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/host_mem_rr_picker.sv
// N-way round-robin picker: first set request at or after ptr, searching cyclically.
// Purely combinational; returns one-hot grant, its index and an any-request flag.
module host_mem_rr_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/host_mem_wr_arb.sv
// Round-robin arbiter sharing one AXI-MM AW/W/B write channel among N_REQ line writers.
// Optional macro HOST_MEM_WR_ARB_BRESP_EN enables outstanding-credit limiting and B routing.
module host_mem_wr_arb
   import host_mem_wr_arb_pkg::*;
#(
   parameter int N_REQ           = 4,
   parameter int ADDR_WIDTH      = 48,
   parameter int DATA_WIDTH      = 512,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 32
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [N_REQ-1:0]                      req_valid,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_data,
   output logic [N_REQ-1:0]                      req_ready,
   output logic [N_REQ-1:0]                      req_bvalid,
   input  logic [N_REQ-1:0]                      req_bready,
   output logic                                  mem_awvalid,
   input  logic                                  mem_awready,
   output logic [ADDR_WIDTH-1:0]                 mem_awaddr,
   output logic [ID_WIDTH-1:0]                   mem_awid,
   output logic [2:0]                            mem_awsize,
   output logic                                  mem_wvalid,
   input  logic                                  mem_wready,
   output logic [DATA_WIDTH-1:0]                 mem_wdata,
   output logic [DATA_WIDTH/8-1:0]               mem_wstrb,
   output logic                                  mem_wlast,
   input  logic                                  mem_bvalid,
   output logic                                  mem_bready,
   input  logic [ID_WIDTH-1:0]                   mem_bid
);

   localparam int IW       = $clog2(N_REQ);
   localparam int LINE_OFS = $clog2(LINE_BYTES);

   t_state                        state, state_nxt;
   logic [IW-1:0]                 ptr;
   logic [IW-1:0]                 gnt_q;
   logic [ADDR_WIDTH-1:LINE_OFS]  addr_q;
   logic [DATA_WIDTH-1:0]         data_q;
   logic                          aw_done, w_done;
   logic [N_REQ-1:0]              pick_gnt;
   logic [IW-1:0]                 pick_idx;
   logic                          pick_any;
   logic                          credit_ok;
   logic                          grant;
   logic                          aw_hs, w_hs, issue_done;
   logic                          unused_addr;

   host_mem_rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
      .req (req_valid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign grant      = (state == ST_IDLE) && credit_ok && pick_any;
   assign aw_hs      = mem_awvalid && mem_awready;
   assign w_hs       = mem_wvalid && mem_wready;
   assign issue_done = (aw_done || aw_hs) && (w_done || w_hs);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant)      state_nxt = ST_ISSUE;
         ST_ISSUE: if (issue_done) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = grant ? pick_gnt : '0;
      mem_awvalid = (state == ST_ISSUE) && !aw_done;
      mem_wvalid  = (state == ST_ISSUE) && !w_done;
   end

   // Line is captured at grant so requesters may change inputs while it is in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr     <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (grant) begin
         ptr     <= IW'(next_rr(int'(pick_idx), N_REQ));
         gnt_q   <= pick_idx;
         addr_q  <= req_addr[pick_idx][ADDR_WIDTH-1:LINE_OFS];
         data_q  <= req_data[pick_idx];
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state == ST_ISSUE) begin
         aw_done <= aw_done || aw_hs;
         w_done  <= w_done || w_hs;
      end
   end

   assign mem_awaddr  = {addr_q, {LINE_OFS{1'b0}}};
   assign mem_awid    = ID_WIDTH'(gnt_q);
   assign mem_awsize  = LINE_AWSIZE;
   assign mem_wdata   = data_q;
   assign mem_wstrb   = '1;
   assign mem_wlast   = 1'b1;
   assign unused_addr = ^req_addr;

`ifdef HOST_MEM_WR_ARB_BRESP_EN
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0] outstanding;
   logic          b_hs;

   assign b_hs      = mem_bvalid && mem_bready;
   assign credit_ok = outstanding < CW'(MAX_OUTSTANDING);

   // Saturates at zero so stray completions after a reset cannot wrap the count.
   always_ff @(posedge clk) begin
      if (!reset_n)                               outstanding <= '0;
      else if (grant && !b_hs)                    outstanding <= outstanding + CW'(1);
      else if (!grant && b_hs && outstanding != 0) outstanding <= outstanding - CW'(1);
   end

   // Unknown IDs are accepted and dropped so the sink never stalls on them.
   always_comb begin
      req_bvalid = '0;
      mem_bready = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         if (mem_bid == ID_WIDTH'(i)) begin
            req_bvalid[i] = mem_bvalid;
            mem_bready    = req_bready[i];
         end
      end
   end
`else
   logic unused_cfg;

   assign credit_ok  = 1'b1;
   assign req_bvalid = '0;
   assign mem_bready = 1'b1;
   assign unused_cfg = (^{req_bready, mem_bid, mem_bvalid}) ^ (MAX_OUTSTANDING < 1);
`endif

endmodule

// File: tb/tb_host_mem_wr_arb.sv
// Self-checking bench for host_mem_wr_arb against a transaction-level reference model.
// Build with or without HOST_MEM_WR_ARB_BRESP_EN; expectations follow the macro.
module tb_host_mem_wr_arb;
   import host_mem_wr_arb_pkg::*;

   localparam int N = 4, AW = 48, DW = 512, IDW = 4, MAXO = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset_n;
   logic [N-1:0]            req_valid;
   logic [N-1:0][AW-1:0]    req_addr;
   logic [N-1:0][DW-1:0]    req_data;
   logic [N-1:0]            req_ready, req_bvalid, req_bready;
   logic                    mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_wlast;
   logic                    mem_bvalid, mem_bready;
   logic [AW-1:0]           mem_awaddr;
   logic [IDW-1:0]          mem_awid, mem_bid;
   logic [2:0]              mem_awsize;
   logic [DW-1:0]           mem_wdata;
   logic [DW/8-1:0]         mem_wstrb;

   host_mem_wr_arb #(
      .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .req_bvalid(req_bvalid), .req_bready(req_bready),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_awid(mem_awid), .mem_awsize(mem_awsize),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bid(mem_bid)
   );

   int total = 0, bad = 0;

   // Reference model: one line in flight at most, with pending AW/W beats and a credit count.
   bit            m_busy, m_aw_left, m_w_left;
   int            m_ptr, m_cnt, m_id;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            gq[$];
   int            aw_beats, w_beats, aw_cyc, w_cyc, cyc;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++)
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [DW-1:0] rdata();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [AW-1:0] raddr();
      logic [63:0] a;
      a = {$urandom, $urandom};
      a[5:0] = '0;
      return a[AW-1:0];
   endfunction

   task automatic step();
      logic [N-1:0] e_rdy, e_bv;
      logic         e_br;
      int           g;
      bit           credit, bhs;
      #1;
      g      = -1;
      e_rdy  = '0;
      credit = 1'b1;
`ifdef HOST_MEM_WR_ARB_BRESP_EN
      credit = (m_cnt < MAXO);
`endif
      if (reset_n && !m_busy && credit) g = pick();
      if (g >= 0) e_rdy[g] = 1'b1;
      e_bv = '0;
      e_br = 1'b1;
`ifdef HOST_MEM_WR_ARB_BRESP_EN
      if (mem_bid < N) begin
         e_bv[mem_bid[1:0]] = mem_bvalid;
         e_br = req_bready[mem_bid[1:0]];
      end
`endif
      bhs = mem_bvalid && e_br;
      chk("req_bvalid", DW'(req_bvalid), DW'(e_bv));
      chk("mem_bready", DW'(mem_bready), DW'(e_br));
      if (reset_n) begin
         chk("req_ready", DW'(req_ready), DW'(e_rdy));
         chk("awvalid", DW'(mem_awvalid), DW'(m_busy && m_aw_left));
         chk("wvalid", DW'(mem_wvalid), DW'(m_busy && m_w_left));
         if (m_busy && m_aw_left) begin
            chk("awaddr", DW'(mem_awaddr), DW'(m_addr));
            chk("awid", DW'(mem_awid), DW'(m_id));
         end
         if (m_busy && m_w_left) chk("wdata", mem_wdata, m_data);
      end
      if (mem_awvalid && mem_awready) begin aw_beats++; aw_cyc = cyc; end
      if (mem_wvalid && mem_wready)   begin w_beats++;  w_cyc  = cyc; end
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
         m_busy = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (g >= 0) begin
            m_busy = 1; m_aw_left = 1; m_w_left = 1;
            m_addr = req_addr[g]; m_data = req_data[g]; m_id = g;
            m_ptr  = (g + 1) % N;
            gq.push_back(g);
         end else if (m_busy) begin
            if (mem_awready) m_aw_left = 0;
            if (mem_wready)  m_w_left  = 0;
            if (!m_aw_left && !m_w_left) m_busy = 0;
         end
`ifdef HOST_MEM_WR_ARB_BRESP_EN
         if (g >= 0 && !bhs) m_cnt++;
         else if (g < 0 && bhs && m_cnt > 0) m_cnt--;
`endif
      end
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0; mem_bvalid = 1'b0; mem_bid = '0;
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
   endtask

   initial begin
      t_req_idx ri;
      int       ngr;
      reset_n = 1'b0; req_valid = '0; req_bready = '1;
      mem_awready = 1'b1; mem_wready = 1'b1; mem_bvalid = 1'b0; mem_bid = '0;
      for (int i = 0; i < N; i++) begin req_addr[i] = raddr(); req_data[i] = rdata(); end
      do_reset();

      // Reset state
      #1;
      chk("rst_awvalid", DW'(mem_awvalid), '0);
      chk("rst_wvalid", DW'(mem_wvalid), '0);
      chk("rst_ready", DW'(req_ready), '0);

      // Single request from requester 2
      ri = 2;
      req_addr[ri] = 48'h1000;
      req_valid = 4'b0100;
      #1;
      chk("single_ready", DW'(req_ready), DW'(4'b0100));
      step();
      req_valid = '0;
      #1;
      chk("single_awaddr", DW'(mem_awaddr), DW'(48'h1000));
      chk("single_awid", DW'(mem_awid), DW'(2));
      chk("single_wstrb", DW'(mem_wstrb), DW'({64{1'b1}}));
      chk("single_awsize", DW'(mem_awsize), DW'(3'b110));
      chk("single_wlast", DW'(mem_wlast), DW'(1'b1));
      step();
      mem_bvalid = 1'b1; mem_bid = 4'd2;
      #1;
`ifdef HOST_MEM_WR_ARB_BRESP_EN
      chk("single_bvalid", DW'(req_bvalid), DW'(4'b0100));
`else
      chk("single_bvalid", DW'(req_bvalid), DW'(4'b0000));
`endif
      step();
      mem_bvalid = 1'b0;

      // All requesters valid, no backpressure; B streams so credit never limits
      do_reset();
      gq.delete();
      req_valid = '1; mem_bvalid = 1'b1; mem_bid = '0;
      for (int i = 0; i < 16; i++) step();
      req_valid = '0; mem_bvalid = 1'b0;
      chk("rr_count", DW'(gq.size()), DW'(8));
      for (int i = 0; i < 8 && i < gq.size(); i++) chk("rr_order", DW'(gq[i]), DW'(i % N));
      step(); step();

      // AW held off 5 cycles while W is accepted
      do_reset();
      req_valid = 4'b0010; mem_awready = 1'b0; mem_wready = 1'b1;
      step();
      req_valid = '0; aw_beats = 0; w_beats = 0;
      for (int i = 0; i < 5; i++) step();
      mem_awready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("bp_aw_beats", DW'(aw_beats), DW'(1));
      chk("bp_w_beats", DW'(w_beats), DW'(1));
      chk("bp_w_first", DW'(w_cyc < aw_cyc), DW'(1));

`ifdef HOST_MEM_WR_ARB_BRESP_EN
      // Credit limit with B withheld, then release one completion
      do_reset();
      gq.delete();
      req_valid = '1;
      for (int i = 0; i < 10; i++) step();
      chk("full_grants", DW'(gq.size()), DW'(MAXO));
      mem_bvalid = 1'b1; mem_bid = 4'd1;
      #1;
      chk("full_no_ready", DW'(req_ready), '0);
      step();
      mem_bvalid = 1'b0;
      #1;
      chk("full_regrant", DW'(|req_ready), DW'(1'b1));
      mem_bvalid = 1'b1; mem_bid = 4'd5;
      step();
      mem_bvalid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      req_valid = '0;
      step(); step();
`else
      // Back-to-back grants without completions
      do_reset();
      gq.delete();
      req_valid = 4'b0001;
      for (int i = 0; i < 80; i++) begin
         mem_bvalid = 1'($urandom); mem_bid = 4'($urandom_range(0, 5)); req_bready = 4'($urandom);
         step();
      end
      req_valid = '0; mem_bvalid = 1'b0; req_bready = '1;
      chk("b2b_grants", DW'(gq.size()), DW'(40));
      step(); step();
`endif

      // Reset in ISSUE after AW is done, then a stray B
      do_reset();
      req_valid = 4'b0010; mem_awready = 1'b1; mem_wready = 1'b0;
      step();
      req_valid = '0;
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; mem_wready = 1'b1;
      #1;
      chk("rst_mid_awvalid", DW'(mem_awvalid), '0);
      chk("rst_mid_wvalid", DW'(mem_wvalid), '0);
      mem_bvalid = 1'b1; mem_bid = 4'd0;
      step();
      mem_bvalid = 1'b0; req_valid = '1;
      #1;
      chk("rst_ptr_zero", DW'(req_ready), DW'(4'b0001));
      for (int i = 0; i < 6; i++) step();

      // Randomized traffic
      ngr = 0;
      for (int i = 0; i < 500; i++) begin
         req_valid = 4'($urandom);
         for (int r = 0; r < N; r++) begin req_addr[r] = raddr(); req_data[r] = rdata(); end
         mem_awready = ($urandom_range(0, 9) < 7);
         mem_wready  = ($urandom_range(0, 9) < 7);
         mem_bvalid  = 1'($urandom);
         mem_bid     = 4'($urandom_range(0, 5));
         req_bready  = 4'($urandom);
         reset_n     = ($urandom_range(0, 99) != 0);
         step();
         ngr++;
      end
      reset_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
